ps2_button_mapper: RTL and testbench

Parametrised PS/2 keyboard-to-arcade-button mapper for emu top levels. It turns `ps2_key` press/release events into a per-button state vector through a runtime-loadable keymap table, and merges that vector with joystick bits into an active-low button bus for the core. It supersedes the fixed per-core `casex` key decoders:
- many keys may map to one button;
- each entry is level or latching (toggle);
- events are queued;
- the whole keymap can be force-released, e.g. when the OSD opens.

---
 rtl/ps2_map_pkg.sv | 47 ++++
 rtl/ps2_evt_fifo.sv | 56 +++++
 rtl/ps2_button_mapper.sv | 190 +++++++++++++++++++
 tb/tb_ps2_button_mapper.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_map_pkg.sv
// Shared types and PS/2 set-2 scan-code constants for the keyboard-to-button mapper.
package ps2_map_pkg;

  localparam int CODE_W      = 9;
  localparam int BTN_FIELD_W = 8;

  typedef struct packed {
    logic                   valid;
    logic                   latch;
    logic [BTN_FIELD_W-1:0] btn;
    logic [CODE_W-1:0]      code;
  } map_entry_t;

  typedef struct packed {
    logic              pressed;
    logic [CODE_W-1:0] code;
  } ps2_evt_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

  // {extended, code}
  localparam logic [CODE_W-1:0] KEY_F1     = 9'h005;
  localparam logic [CODE_W-1:0] KEY_F2     = 9'h006;
  localparam logic [CODE_W-1:0] KEY_F3     = 9'h004;
  localparam logic [CODE_W-1:0] KEY_F4     = 9'h00C;
  localparam logic [CODE_W-1:0] KEY_1      = 9'h016;
  localparam logic [CODE_W-1:0] KEY_2      = 9'h01E;
  localparam logic [CODE_W-1:0] KEY_5      = 9'h02E;
  localparam logic [CODE_W-1:0] KEY_ESC    = 9'h076;
  localparam logic [CODE_W-1:0] KEY_LALT   = 9'h011;
  localparam logic [CODE_W-1:0] KEY_LSHIFT = 9'h012;
  localparam logic [CODE_W-1:0] KEY_LCTRL  = 9'h014;
  localparam logic [CODE_W-1:0] KEY_SPACE  = 9'h029;
  localparam logic [CODE_W-1:0] KEY_M      = 9'h03A;
  localparam logic [CODE_W-1:0] KEY_LEFT   = 9'h16B;
  localparam logic [CODE_W-1:0] KEY_DOWN   = 9'h172;
  localparam logic [CODE_W-1:0] KEY_RIGHT  = 9'h174;
  localparam logic [CODE_W-1:0] KEY_UP     = 9'h175;

  function automatic logic entry_hit(input map_entry_t entry, input ps2_evt_t evt);
    return entry.valid && (entry.code == evt.code);
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Small synchronous FIFO of PS/2 events with flush; the parent decides what to drop when full.
module ps2_evt_fifo
  import ps2_map_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  logic     pop_i,
  input  logic     flush_i,
  input  ps2_evt_t wdata_i,
  output ps2_evt_t rdata_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

  ps2_evt_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone define which slots are live.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/ps2_button_mapper.sv
// PS/2 key events -> per-button state through a runtime keymap table, merged with joystick bits.
module ps2_button_mapper
  import ps2_map_pkg::*;
#(
  parameter  int NUM_BTN    = 8,
  parameter  int MAP_DEPTH  = 16,
  parameter  int FIFO_DEPTH = 4,
  localparam int IDX_W      = $clog2(MAP_DEPTH),
  localparam int BTN_W      = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
  input  logic               clk_25,
  input  logic               RESET_L,
  input  logic [10:0]        ps2_key,
  input  logic               map_wr,
  input  logic [IDX_W-1:0]   map_idx,
  input  logic [CODE_W-1:0]  map_code,
  input  logic [BTN_W-1:0]   map_btn,
  input  logic               map_latch,
  input  logic               map_valid,
  input  logic               release_all,
  input  logic [NUM_BTN-1:0] joy_in,
  input  logic               ovf_clr,
  output logic [NUM_BTN-1:0] btn_state,
  output logic [NUM_BTN-1:0] buttons_l,
  output logic               ovf,
  output logic               busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAP_DEPTH - 1);

  logic           armed_q, prev_toggle_q;
  logic           toggle_evt, fifo_push, fifo_pop, fifo_full, fifo_empty, evt_drop;
  ps2_evt_t       new_evt, fifo_rdata;

  scan_state_t    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  ps2_evt_t       cur_evt_q, cur_evt_d;
  logic           scan_active, scan_hit;

  map_entry_t     table_q [MAP_DEPTH];
  logic [MAP_DEPTH-1:0] key_down_q, key_down_d;
  logic [MAP_DEPTH-1:0] latch_q, latch_d;
  logic [NUM_BTN-1:0]   btn_state_q, btn_state_d;
  logic           ovf_q, ovf_d;

  // The first edge after reset only captures the toggle level, so a stale level is never an event.
  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      armed_q       <= 1'b0;
      prev_toggle_q <= 1'b0;
    end else begin
      armed_q       <= 1'b1;
      prev_toggle_q <= ps2_key[10];
    end
  end

  assign toggle_evt = armed_q && (ps2_key[10] != prev_toggle_q) && !release_all;
  assign fifo_push  = toggle_evt && (!fifo_full || fifo_pop);
  assign evt_drop   = toggle_evt && fifo_full && !fifo_pop;
  assign new_evt    = '{pressed: ps2_key[9], code: ps2_key[8:0]};

  ps2_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_evt_fifo (
    .clk     (clk_25),
    .rst_n   (RESET_L),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (release_all),
    .wdata_i (new_evt),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cur_evt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cur_evt_q <= cur_evt_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cur_evt_d = cur_evt_q;
    if (release_all) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_d   = ST_SCAN;
            idx_d     = '0;
            cur_evt_d = fifo_rdata;
          end
        end
        ST_SCAN: begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    scan_active = (state_q == ST_SCAN);
    fifo_pop    = (state_q == ST_IDLE) && !fifo_empty && !release_all;
    busy        = (state_q != ST_IDLE) || !fifo_empty;
  end

  assign scan_hit = scan_active && entry_hit(table_q[idx_q], cur_evt_q);

  // Table entries come up invalid; the scan reads the pre-write entry when indices collide.
  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      table_q <= '{default: '0};
    end else if (map_wr) begin
      table_q[map_idx] <= '{valid: map_valid, latch: map_latch,
                            btn: BTN_FIELD_W'(map_btn), code: map_code};
    end
  end

  // Latch entries flip only on a fresh press, so typematic repeats leave the latch alone.
  always_comb begin
    key_down_d = key_down_q;
    latch_d    = latch_q;
    if (release_all) begin
      key_down_d = '0;
      latch_d    = '0;
    end else begin
      if (scan_hit) begin
        if (!table_q[idx_q].latch) begin
          key_down_d[idx_q] = cur_evt_q.pressed;
        end else if (!cur_evt_q.pressed) begin
          key_down_d[idx_q] = 1'b0;
        end else if (!key_down_q[idx_q]) begin
          latch_d[idx_q]    = ~latch_q[idx_q];
          key_down_d[idx_q] = 1'b1;
        end
      end
      if (map_wr) begin
        key_down_d[map_idx] = 1'b0;
        latch_d[map_idx]    = 1'b0;
      end
    end
  end

  always_comb begin
    btn_state_d = '0;
    if (!release_all) begin
      for (int b = 0; b < NUM_BTN; b++) begin
        for (int e = 0; e < MAP_DEPTH; e++) begin
          if (table_q[e].valid && (table_q[e].btn == BTN_FIELD_W'(b)))
            btn_state_d[b] = btn_state_d[b] | (table_q[e].latch ? latch_q[e] : key_down_q[e]);
        end
      end
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (evt_drop)     ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      key_down_q  <= '0;
      latch_q     <= '0;
      btn_state_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      key_down_q  <= key_down_d;
      latch_q     <= latch_d;
      btn_state_q <= btn_state_d;
      ovf_q       <= ovf_d;
    end
  end

  assign btn_state = btn_state_q;
  assign buttons_l = ~(btn_state_q | joy_in);
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ps2_button_mapper.sv
// Scoreboard bench: stimulus schedules expected outputs per cycle, a negedge monitor compares them.
module tb_ps2_button_mapper;
  import ps2_map_pkg::*;

  localparam int NB = 8;
  localparam int MD = 16;
  localparam int FD = 4;

  logic          clk_25 = 1'b0;
  logic          RESET_L;
  logic [10:0]   ps2_key;
  logic          map_wr;
  logic [3:0]    map_idx;
  logic [8:0]    map_code;
  logic [2:0]    map_btn;
  logic          map_latch;
  logic          map_valid;
  logic          release_all;
  logic [NB-1:0] joy_in;
  logic          ovf_clr;
  logic [NB-1:0] btn_state;
  logic [NB-1:0] buttons_l;
  logic          ovf;
  logic          busy;

  ps2_button_mapper #(.NUM_BTN(NB), .MAP_DEPTH(MD), .FIFO_DEPTH(FD)) dut (
    .clk_25      (clk_25),
    .RESET_L     (RESET_L),
    .ps2_key     (ps2_key),
    .map_wr      (map_wr),
    .map_idx     (map_idx),
    .map_code    (map_code),
    .map_btn     (map_btn),
    .map_latch   (map_latch),
    .map_valid   (map_valid),
    .release_all (release_all),
    .joy_in      (joy_in),
    .ovf_clr     (ovf_clr),
    .btn_state   (btn_state),
    .buttons_l   (buttons_l),
    .ovf         (ovf),
    .busy        (busy)
  );

  always #5 clk_25 = ~clk_25;

  int cyc = 0;
  always @(posedge clk_25) cyc <= cyc + 1;

  typedef enum {K_BTN, K_BL, K_OVF, K_BUSY} kind_t;
  typedef struct {
    int         at;
    kind_t      kind;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  logic       lat_p [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] lat_x [9] = '{8'h02, 8'h02, 8'h00, 8'h00, 8'h02, 8'h02, 8'h02, 8'h00, 8'h00};
  logic       ov_p  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [8:0] ov_c  [6] = '{KEY_F3, KEY_F3, KEY_F3, KEY_F3, KEY_F3, KEY_LCTRL};

  task automatic check(input exp_t e);
    logic [7:0] act;
    case (e.kind)
      K_BTN:   act = btn_state;
      K_BL:    act = buttons_l;
      K_OVF:   act = {7'b0, ovf};
      default: act = {7'b0, busy};
    endcase
    n_vec++;
    if (act !== e.val) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", e.name, cyc, act, e.val);
    end
  endtask

  always @(negedge clk_25) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        check(sb[i]);
        sb.delete(i);
      end else if (sb[i].at < cyc) begin
        n_vec++;
        n_bad++;
        $display("FAIL %s: cycle %0d was never sampled (now %0d)", sb[i].name, sb[i].at, cyc);
        sb.delete(i);
      end
    end
  end

  task automatic exp_at(input int at, input kind_t k, input logic [7:0] v, input string nm);
    exp_t e;
    e.at = at; e.kind = k; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_25);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic send(input logic pressed, input logic [8:0] code, output int e0);
    ps2_key = {~ps2_key[10], pressed, code};
    e0      = cyc + 1;
  endtask

  task automatic write_map(input logic [3:0] idx, input logic [8:0] code, input logic [2:0] btn,
                           input logic latch, input logic valid);
    map_wr = 1'b1; map_idx = idx; map_code = code; map_btn = btn;
    map_latch = latch; map_valid = valid;
    tick();
    map_wr = 1'b0;
  endtask

  initial begin
    int e0, p1, r, c;
    RESET_L = 1'b0; ps2_key = 11'h400; map_wr = 1'b0; map_idx = '0; map_code = '0;
    map_btn = '0; map_latch = 1'b0; map_valid = 1'b0; release_all = 1'b0;
    joy_in = '0; ovf_clr = 1'b0;
    tick(3);
    exp_at(cyc, K_BTN, 8'h00, "rst_btn");
    exp_at(cyc, K_BL, 8'hFF, "rst_bl");
    exp_at(cyc, K_OVF, 8'h00, "rst_ovf");
    exp_at(cyc, K_BUSY, 8'h00, "rst_busy");
    RESET_L = 1'b1;
    r = cyc;
    exp_at(r + 3, K_BUSY, 8'h00, "no_phantom_a");
    exp_at(r + 6, K_BUSY, 8'h00, "no_phantom_b");
    wait_until(r + 6);

    joy_in = 8'h01;
    exp_at(cyc, K_BL, 8'hFE, "joy_bl");
    exp_at(cyc, K_BTN, 8'h00, "joy_btn");
    tick();
    joy_in = '0;

    // Level entry: M on button 3.
    write_map(4'd0, KEY_M, 3'd3, 1'b0, 1'b1);
    send(1'b1, KEY_M, e0);
    exp_at(e0 + 1, K_BUSY, 8'h01, "lvl_busy");
    exp_at(e0 + 2, K_BTN, 8'h00, "lvl_press_early");
    exp_at(e0 + 3, K_BTN, 8'h08, "lvl_press");
    exp_at(e0 + 3, K_BL, 8'hF7, "lvl_press_bl");
    exp_at(e0 + 16, K_BUSY, 8'h01, "lvl_busy_last");
    exp_at(e0 + 17, K_BUSY, 8'h00, "lvl_idle");
    tick();
    wait_until(e0 + 18);
    send(1'b0, KEY_M, e0);
    exp_at(e0 + 2, K_BTN, 8'h08, "lvl_rel_early");
    exp_at(e0 + 3, K_BTN, 8'h00, "lvl_rel");
    exp_at(e0 + 3, K_BL, 8'hFF, "lvl_rel_bl");
    tick();
    wait_until(e0 + 18);

    // Two keys on button 4.
    write_map(4'd0, KEY_LCTRL, 3'd4, 1'b0, 1'b1);
    write_map(4'd5, KEY_M, 3'd4, 1'b0, 1'b1);
    send(1'b1, KEY_LCTRL, e0);
    exp_at(e0 + 3, K_BTN, 8'h10, "m2o_ctrl");
    tick(); wait_until(e0 + 18);
    send(1'b1, KEY_M, e0);
    exp_at(e0 + 17, K_BTN, 8'h10, "m2o_both");
    tick(); wait_until(e0 + 18);
    send(1'b0, KEY_LCTRL, e0);
    exp_at(e0 + 3, K_BTN, 8'h10, "m2o_hold");
    exp_at(e0 + 17, K_BTN, 8'h10, "m2o_hold_end");
    tick(); wait_until(e0 + 18);
    send(1'b0, KEY_M, e0);
    exp_at(e0 + 7, K_BTN, 8'h10, "m2o_rel_early");
    exp_at(e0 + 8, K_BTN, 8'h00, "m2o_rel");
    tick(); wait_until(e0 + 18);

    // Latch entry 2: F3 on button 1.
    write_map(4'd2, KEY_F3, 3'd1, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) begin
      send(lat_p[i], KEY_F3, e0);
      exp_at(e0 + 4, K_BTN, (i == 0) ? 8'h00 : lat_x[i-1], $sformatf("latch_pre_%0d", i));
      exp_at(e0 + 5, K_BTN, lat_x[i], $sformatf("latch_post_%0d", i));
      tick();
      wait_until(e0 + 18);
    end

    // Six toggles back-to-back into a 4-deep queue: e1..e5 kept, e6 dropped.
    p1 = cyc + 1;
    exp_at(p1 + 4, K_OVF, 8'h00, "ovf_before");
    exp_at(p1 + 5, K_OVF, 8'h01, "ovf_set");
    exp_at(p1 + 72, K_BTN, 8'h00, "ovf_e5_early");
    exp_at(p1 + 73, K_BTN, 8'h02, "ovf_e5_done");
    exp_at(p1 + 84, K_BUSY, 8'h01, "ovf_busy");
    exp_at(p1 + 85, K_BUSY, 8'h00, "ovf_drained");
    exp_at(p1 + 90, K_BTN, 8'h02, "ovf_e6_dropped");
    exp_at(p1 + 90, K_OVF, 8'h01, "ovf_sticky");
    for (int i = 0; i < 6; i++) begin
      send(ov_p[i], ov_c[i], e0);
      tick();
    end
    wait_until(p1 + 90);
    c = cyc;
    ovf_clr = 1'b1;
    exp_at(c + 1, K_OVF, 8'h00, "ovf_cleared");
    tick();
    ovf_clr = 1'b0;

    // release_all with Ctrl held, one event scanning and one queued.
    send(1'b1, KEY_LCTRL, e0);
    exp_at(e0 + 2, K_BTN, 8'h02, "rall_pre");
    exp_at(e0 + 3, K_BTN, 8'h12, "rall_held");
    tick(); wait_until(e0 + 18);
    send(1'b1, KEY_M, e0);
    tick();
    send(1'b0, KEY_LCTRL, r);
    tick();
    wait_until(e0 + 4);
    release_all = 1'b1;
    exp_at(e0 + 4, K_BUSY, 8'h01, "rall_busy_pre");
    exp_at(e0 + 4, K_BTN, 8'h12, "rall_btn_pre");
    exp_at(e0 + 5, K_BTN, 8'h00, "rall_btn");
    exp_at(e0 + 5, K_BUSY, 8'h00, "rall_busy");
    exp_at(e0 + 25, K_BTN, 8'h00, "rall_btn_later");
    exp_at(e0 + 25, K_BUSY, 8'h00, "rall_busy_later");
    tick();
    release_all = 1'b0;
    wait_until(e0 + 26);

    // Asynchronous reset in the middle of a scan.
    send(1'b1, KEY_LCTRL, e0);
    exp_at(e0 + 3, K_BTN, 8'h10, "rstmid_pre_btn");
    exp_at(e0 + 4, K_BUSY, 8'h01, "rstmid_pre_busy");
    tick();
    wait_until(e0 + 5);
    RESET_L = 1'b0;
    exp_at(e0 + 5, K_BTN, 8'h00, "rstmid_btn");
    exp_at(e0 + 5, K_BUSY, 8'h00, "rstmid_busy");
    exp_at(e0 + 5, K_BL, 8'hFF, "rstmid_bl");
    tick(2);
    RESET_L = 1'b1;
    tick(3);

    foreach (sb[i]) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: cycle %0d never reached", sb[i].name, sb[i].at);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    done = 1'b1;
    $finish;
  end

  initial begin
    #100000;
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
    end
  end

endmodule
